trap_sequencer: RTL and testbench

User-mode trap sequencer for the RISC-V core. It sits directly upstream of the control/status register file. It takes per-instruction exception flags from the datapath and picks the highest-priority cause. It then writes uepc, ucause and utval through the register file's single write port over successive cycles, and redirects the PC to utvec. It also handles uret by redirecting to uepc.

---
 rtl/trap_sequencer_pkg.sv | 35 +++
 rtl/trap_prio_enc.sv | 47 ++++
 rtl/trap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg
//   Shared definitions for the user-mode trap sequencer: CSR addresses,
//   ucause codes, FSM state encoding and the tval source select.
package trap_sequencer_pkg;

    // User-mode CSR addresses
    localparam logic [11:0] CSR_USTATUS = 12'h000;
    localparam logic [11:0] CSR_UTVEC   = 12'h005;
    localparam logic [11:0] CSR_UEPC    = 12'h041;
    localparam logic [11:0] CSR_UCAUSE  = 12'h042;
    localparam logic [11:0] CSR_UTVAL   = 12'h043;

    // ucause exception codes
    localparam logic [3:0] CAUSE_MISFETCH = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_MISLOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISSTORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL    = 4'd8;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_EPC   = 3'd1;
    localparam logic [2:0] ST_W_CAUSE = 3'd2;
    localparam logic [2:0] ST_W_TVAL  = 3'd3;
    localparam logic [2:0] ST_REDIR   = 3'd4;
    localparam logic [2:0] ST_RET     = 3'd5;

    // Source of the utval value
    typedef enum logic [1:0] {
        TVAL_ZERO    = 2'd0,
        TVAL_BADADDR = 2'd1,
        TVAL_INSTR   = 2'd2
    } tvalSel_t;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc
//   Combinational priority encoder for the exception flags.
//   Priority (highest first): misaligned fetch, illegal, ecall,
//   misaligned load, misaligned store.
// Ports:
//   iMisFetch..iMisStore  exception flags
//   oValid                any flag set
//   oCause                ucause code of the winning flag
//   oTvalSel              where utval comes from for the winning flag
module trap_prio_enc
    import trap_sequencer_pkg::*;
(
    input  logic       iMisFetch,
    input  logic       iIllegal,
    input  logic       iEcall,
    input  logic       iMisLoad,
    input  logic       iMisStore,
    output logic       oValid,
    output logic [3:0] oCause,
    output tvalSel_t   oTvalSel
);

    always_comb begin
        oValid   = 1'b1;
        oCause   = CAUSE_MISFETCH;
        oTvalSel = TVAL_ZERO;
        if (iMisFetch) begin
            oCause   = CAUSE_MISFETCH;
            oTvalSel = TVAL_BADADDR;
        end else if (iIllegal) begin
            oCause   = CAUSE_ILLEGAL;
            oTvalSel = TVAL_INSTR;
        end else if (iEcall) begin
            oCause   = CAUSE_ECALL;
            oTvalSel = TVAL_ZERO;
        end else if (iMisLoad) begin
            oCause   = CAUSE_MISLOAD;
            oTvalSel = TVAL_BADADDR;
        end else if (iMisStore) begin
            oCause   = CAUSE_MISSTORE;
            oTvalSel = TVAL_BADADDR;
        end else begin
            oValid   = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   User-mode trap sequencer. Picks the highest-priority exception of the
//   committing instruction, writes uepc/ucause/utval through the CSR
//   file's single write port on successive cycles and redirects to utvec.
//   A uret redirects to uepc.
// Ports:
//   iCLK, iRST          clock, asynchronous active-high reset
//   iInstrValid, iPC, iBadAddr, iInstr, iMisFetch..iMisStore, iUret
//                       commit-stage instruction info and exception flags
//   iUtvec, iUepc       current CSR values
//   oCSRWrite/Addr/WData  CSR write port
//   oStall, oFlush, oRedirect, oPCTarget  pipeline control
//   oBusy               sequencer not idle
//   oTrapCount          saturating count of traps taken
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iInstrValid,
    input  logic [XLEN-1:0] iPC,
    input  logic [XLEN-1:0] iBadAddr,
    input  logic [31:0]     iInstr,
    input  logic            iMisFetch,
    input  logic            iIllegal,
    input  logic            iEcall,
    input  logic            iMisLoad,
    input  logic            iMisStore,
    input  logic            iUret,
    input  logic [XLEN-1:0] iUtvec,
    input  logic [XLEN-1:0] iUepc,
    output logic            oCSRWrite,
    output logic [11:0]     oCSRAddr,
    output logic [XLEN-1:0] oCSRWData,
    output logic            oStall,
    output logic            oFlush,
    output logic            oRedirect,
    output logic [XLEN-1:0] oPCTarget,
    output logic            oBusy,
    output logic [CNTW-1:0] oTrapCount
);

    logic [2:0]      state;
    logic [2:0]      nextState;
    logic [XLEN-1:0] pcLatch;
    logic [3:0]      causeLatch;
    logic [XLEN-1:0] tvalLatch;
    logic [XLEN-1:0] tvalNext;
    logic [CNTW-1:0] trapCount;

    logic            encValid;
    logic [3:0]      encCause;
    tvalSel_t        encTvalSel;
    logic            trapReq;
    logic            retReq;

    trap_prio_enc uPrioEnc (
        .iMisFetch (iMisFetch),
        .iIllegal  (iIllegal),
        .iEcall    (iEcall),
        .iMisLoad  (iMisLoad),
        .iMisStore (iMisStore),
        .oValid    (encValid),
        .oCause    (encCause),
        .oTvalSel  (encTvalSel)
    );

    // An exception always beats a simultaneous uret.
    assign trapReq = iInstrValid && encValid;
    assign retReq  = iInstrValid && iUret && !encValid;

    always_comb begin
        tvalNext = '0;
        case (encTvalSel)
            TVAL_BADADDR: tvalNext = iBadAddr;
            TVAL_INSTR:   tvalNext = XLEN'(iInstr);
            default:      tvalNext = '0;
        endcase
    end

    always_comb begin
        nextState = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (trapReq)     nextState = ST_W_EPC;
                else if (retReq) nextState = ST_RET;
                else             nextState = ST_IDLE;
            end
            ST_W_EPC:   nextState = ST_W_CAUSE;
            ST_W_CAUSE: nextState = ST_W_TVAL;
            ST_W_TVAL:  nextState = ST_REDIR;
            ST_REDIR:   nextState = ST_IDLE;
            ST_RET:     nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= ST_IDLE;
            pcLatch    <= '0;
            causeLatch <= '0;
            tvalLatch  <= '0;
            trapCount  <= '0;
        end else begin
            state <= nextState;
            if (state == ST_IDLE && trapReq) begin
                pcLatch    <= iPC;
                causeLatch <= encCause;
                tvalLatch  <= tvalNext;
                if (trapCount != '1)
                    trapCount <= trapCount + 1'b1;
            end
        end
    end

    // Outputs decode only the state register and the latches; the redirect
    // targets read iUtvec/iUepc in the redirect cycle itself so the utvec
    // value reflects any CSR update completed on the preceding write.
    always_comb begin
        oCSRWrite = 1'b0;
        oCSRAddr  = '0;
        oCSRWData = '0;
        oFlush    = 1'b0;
        oRedirect = 1'b0;
        oPCTarget = '0;
        case (state)
            ST_W_EPC: begin
                oCSRWrite = 1'b1;
                oCSRAddr  = CSR_UEPC;
                oCSRWData = pcLatch & ~XLEN'(1);
            end
            ST_W_CAUSE: begin
                oCSRWrite = 1'b1;
                oCSRAddr  = CSR_UCAUSE;
                oCSRWData = XLEN'(causeLatch);
            end
            ST_W_TVAL: begin
                oCSRWrite = 1'b1;
                oCSRAddr  = CSR_UTVAL;
                oCSRWData = tvalLatch;
            end
            ST_REDIR: begin
                oRedirect = 1'b1;
                oFlush    = 1'b1;
                oPCTarget = iUtvec & ~XLEN'(3);
            end
            ST_RET: begin
                oRedirect = 1'b1;
                oFlush    = 1'b1;
                oPCTarget = iUepc;
            end
            default: ;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign oStall     = !iRST && ((state != ST_IDLE) || trapReq || retReq);
    assign oBusy      = (state != ST_IDLE);
    assign oTrapCount = trapCount;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    localparam int XLEN = 32;
    localparam int CNTW = 4;

    logic            iCLK = 1'b0;
    logic            iRST;
    logic            iInstrValid;
    logic [XLEN-1:0] iPC;
    logic [XLEN-1:0] iBadAddr;
    logic [31:0]     iInstr;
    logic            iMisFetch, iIllegal, iEcall, iMisLoad, iMisStore, iUret;
    logic [XLEN-1:0] iUtvec;
    logic [XLEN-1:0] iUepc;
    logic            oCSRWrite;
    logic [11:0]     oCSRAddr;
    logic [XLEN-1:0] oCSRWData;
    logic            oStall, oFlush, oRedirect, oBusy;
    logic [XLEN-1:0] oPCTarget;
    logic [CNTW-1:0] oTrapCount;

    int checks = 0;
    int errors = 0;

    // Per-cycle samples of one sequence (index = cycle after acceptance)
    logic        sWr    [1:6];
    logic [11:0] sAddr  [1:6];
    logic [31:0] sData  [1:6];
    logic        sRedir [1:6];
    logic        sFlush [1:6];
    logic [31:0] sTgt   [1:6];
    logic        sBusy  [1:6];

    trap_sequencer #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iInstrValid (iInstrValid),
        .iPC         (iPC),
        .iBadAddr    (iBadAddr),
        .iInstr      (iInstr),
        .iMisFetch   (iMisFetch),
        .iIllegal    (iIllegal),
        .iEcall      (iEcall),
        .iMisLoad    (iMisLoad),
        .iMisStore   (iMisStore),
        .iUret       (iUret),
        .iUtvec      (iUtvec),
        .iUepc       (iUepc),
        .oCSRWrite   (oCSRWrite),
        .oCSRAddr    (oCSRAddr),
        .oCSRWData   (oCSRWData),
        .oStall      (oStall),
        .oFlush      (oFlush),
        .oRedirect   (oRedirect),
        .oPCTarget   (oPCTarget),
        .oBusy       (oBusy),
        .oTrapCount  (oTrapCount)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearIn();
        iInstrValid = 1'b0;
        iMisFetch = 1'b0; iIllegal = 1'b0; iEcall = 1'b0;
        iMisLoad = 1'b0; iMisStore = 1'b0; iUret = 1'b0;
        // Scramble live inputs so written values must come from the latches
        iPC = 32'hDEAD_BEE0; iBadAddr = 32'hBAD0_BAD0; iInstr = 32'h1234_5678;
    endtask

    // Samples cycles 1..n after the acceptance cycle; optionally raises
    // iEcall (with iInstrValid) during cycle injectAt.
    task automatic runSeq(input int n, input int injectAt);
        for (int c = 1; c <= n; c++) begin
            @(negedge iCLK);
            sWr[c] = oCSRWrite; sAddr[c] = oCSRAddr; sData[c] = oCSRWData;
            sRedir[c] = oRedirect; sFlush[c] = oFlush; sTgt[c] = oPCTarget;
            sBusy[c] = oBusy;
            clearIn();
            if (c + 1 == injectAt) begin
                iInstrValid = 1'b1;
                iEcall = 1'b1;
            end
        end
    endtask

    function automatic int countWr(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(sWr[c]);
        return s;
    endfunction

    function automatic int countRedir(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(sRedir[c]);
        return s;
    endfunction

    initial begin
        iRST = 1'b1;
        clearIn();
        iUtvec = 32'h0000_0401;
        iUepc  = 32'h0000_0104;

        // Reset state
        repeat (2) @(negedge iCLK);
        chk("rst_wr", {31'b0, oCSRWrite}, 32'd0);
        chk("rst_redir", {31'b0, oRedirect}, 32'd0);
        chk("rst_busy", {31'b0, oBusy}, 32'd0);
        chk("rst_stall", {31'b0, oStall}, 32'd0);
        chk("rst_cnt", 32'(oTrapCount), 32'd0);
        iRST = 1'b0;
        @(negedge iCLK);

        // Misaligned load
        iInstrValid = 1'b1; iMisLoad = 1'b1;
        iPC = 32'h0000_0100; iBadAddr = 32'h0000_2003;
        #1 chk("ml_stall0", {31'b0, oStall}, 32'd1);
        runSeq(5, 0);
        chk("ml_wr1", {31'b0, sWr[1]}, 32'd1);
        chk("ml_addr1", 32'(sAddr[1]), 32'h041);
        chk("ml_data1", sData[1], 32'h0000_0100);
        chk("ml_addr2", 32'(sAddr[2]), 32'h042);
        chk("ml_data2", sData[2], 32'd4);
        chk("ml_addr3", 32'(sAddr[3]), 32'h043);
        chk("ml_data3", sData[3], 32'h0000_2003);
        chk("ml_redir4", {31'b0, sRedir[4]}, 32'd1);
        chk("ml_flush4", {31'b0, sFlush[4]}, 32'd1);
        chk("ml_tgt4", sTgt[4], 32'h0000_0400);
        chk("ml_wr4", {31'b0, sWr[4]}, 32'd0);
        chk("ml_busy5", {31'b0, sBusy[5]}, 32'd0);
        chk("ml_tgt5", sTgt[5], 32'd0);
        chk("ml_nwr", 32'(countWr(5)), 32'd3);
        chk("ml_cnt", 32'(oTrapCount), 32'd1);

        // Illegal + misaligned load + uret: illegal wins, uret dropped
        iInstrValid = 1'b1; iIllegal = 1'b1; iMisLoad = 1'b1; iUret = 1'b1;
        iPC = 32'h0000_0201; iInstr = 32'hFFFF_FFFF; iBadAddr = 32'h0000_0777;
        runSeq(5, 0);
        chk("il_data1", sData[1], 32'h0000_0200);
        chk("il_data2", sData[2], 32'd2);
        chk("il_data3", sData[3], 32'hFFFF_FFFF);
        chk("il_nwr", 32'(countWr(5)), 32'd3);
        chk("il_tgt4", sTgt[4], 32'h0000_0400);
        chk("il_cnt", 32'(oTrapCount), 32'd2);

        // uret
        iInstrValid = 1'b1; iUret = 1'b1;
        #1 chk("ur_stall0", {31'b0, oStall}, 32'd1);
        runSeq(3, 0);
        chk("ur_redir1", {31'b0, sRedir[1]}, 32'd1);
        chk("ur_flush1", {31'b0, sFlush[1]}, 32'd1);
        chk("ur_tgt1", sTgt[1], 32'h0000_0104);
        chk("ur_busy2", {31'b0, sBusy[2]}, 32'd0);
        chk("ur_redir2", {31'b0, sRedir[2]}, 32'd0);
        chk("ur_nwr", 32'(countWr(3)), 32'd0);
        chk("ur_cnt", 32'(oTrapCount), 32'd2);

        // ecall, with a second ecall arriving mid-sequence (cycle 2)
        iInstrValid = 1'b1; iEcall = 1'b1; iPC = 32'h0000_0300;
        runSeq(6, 2);
        chk("ec_data1", sData[1], 32'h0000_0300);
        chk("ec_data2", sData[2], 32'd8);
        chk("ec_data3", sData[3], 32'd0);
        chk("ec_nwr", 32'(countWr(6)), 32'd3);
        chk("ec_nredir", 32'(countRedir(6)), 32'd1);
        chk("ec_busy6", {31'b0, sBusy[6]}, 32'd0);
        chk("ec_cnt", 32'(oTrapCount), 32'd3);

        // Reset asserted during W_CAUSE
        iInstrValid = 1'b1; iMisFetch = 1'b1; iPC = 32'h0000_0500;
        runSeq(2, 0);
        chk("rs_addr1", 32'(sAddr[1]), 32'h041);
        chk("rs_addr2", 32'(sAddr[2]), 32'h042);
        iRST = 1'b1;
        #1;
        chk("rs_wr", {31'b0, oCSRWrite}, 32'd0);
        chk("rs_addr", 32'(oCSRAddr), 32'd0);
        chk("rs_data", oCSRWData, 32'd0);
        chk("rs_stall", {31'b0, oStall}, 32'd0);
        chk("rs_busy", {31'b0, oBusy}, 32'd0);
        chk("rs_cnt", 32'(oTrapCount), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        runSeq(4, 0);
        chk("rs_nredir", 32'(countRedir(4)), 32'd0);
        chk("rs_nwr", 32'(countWr(4)), 32'd0);

        // Misaligned fetch beats ecall; utval is the bad address
        iInstrValid = 1'b1; iMisFetch = 1'b1; iEcall = 1'b1;
        iPC = 32'h0000_0600; iBadAddr = 32'h0000_0602;
        runSeq(5, 0);
        chk("mf_data2", sData[2], 32'd0);
        chk("mf_data3", sData[3], 32'h0000_0602);
        chk("mf_cnt", 32'(oTrapCount), 32'd1);

        // Misaligned store
        iInstrValid = 1'b1; iMisStore = 1'b1;
        iPC = 32'h0000_0700; iBadAddr = 32'h0000_0905;
        runSeq(5, 0);
        chk("ms_data2", sData[2], 32'd6);
        chk("ms_data3", sData[3], 32'h0000_0905);
        chk("ms_cnt", 32'(oTrapCount), 32'd2);

        // Saturation: 2^CNTW+3 back-to-back ecalls in total after reset
        for (int t = 0; t < (1 << CNTW) + 1; t++) begin
            iInstrValid = 1'b1; iEcall = 1'b1;
            runSeq(5, 0);
            if (t == 12) chk("sat_cnt15", 32'(oTrapCount), 32'd15);
        end
        chk("sat_cnt", 32'(oTrapCount), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
